uart_xcvr_param: RTL and testbench

UART_XCVR_PARAM -- requirements
Module: uart_xcvr_param

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_xcvr_param.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_uart_xcvr_param.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings and the common TX/RX state type.
// The PARITY state only exists when UART_PARITY_EN is defined.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  // Mode 2'b11 deliberately falls through to "no parity".
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: held at zero by i_clr, otherwise wraps every CLKS_PER_BIT cycles.
// o_mid marks the sampling point, o_eob the last cycle of the bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_mid,
  output logic o_eob
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr || o_eob) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_mid = (r_cnt == CNT_W'(CLKS_PER_BIT / 2));
  assign o_eob = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_xcvr_param.sv
// Independent UART transmitter and receiver sharing one clock.
// Define UART_PARITY_EN to build parity generation/checking; otherwise parity_mode is ignored.
module uart_xcvr_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic [1:0]        parity_mode,
  output logic              tx,
  output logic              tx_busy,
  input  logic              rx,
  output logic [DATA_W-1:0] dout,
  output logic              ready,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int BIT_W = 4;
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  uart_state_e       r_tx_state, w_tx_state_next;
  logic              r_tx, w_tx_next;
  logic              r_tx_busy, w_tx_busy_next;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift_next;
  logic [BIT_W-1:0]  r_tx_bit, w_tx_bit_next;
  logic              w_tx_clr, w_tx_mid_unused, w_tx_eob;
`ifdef UART_PARITY_EN
  logic              r_tx_par_on, w_tx_par_on_next;
  logic              r_tx_par_bit, w_tx_par_bit_next;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_tx_clr),
    .o_mid (w_tx_mid_unused),
    .o_eob (w_tx_eob)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state   <= ST_IDLE;
      r_tx         <= 1'b1;
      r_tx_busy    <= 1'b0;
      r_tx_shift   <= '0;
      r_tx_bit     <= '0;
`ifdef UART_PARITY_EN
      r_tx_par_on  <= 1'b0;
      r_tx_par_bit <= 1'b0;
`endif
    end else begin
      r_tx_state   <= w_tx_state_next;
      r_tx         <= w_tx_next;
      r_tx_busy    <= w_tx_busy_next;
      r_tx_shift   <= w_tx_shift_next;
      r_tx_bit     <= w_tx_bit_next;
`ifdef UART_PARITY_EN
      r_tx_par_on  <= w_tx_par_on_next;
      r_tx_par_bit <= w_tx_par_bit_next;
`endif
    end
  end

  // tx is registered, so the next line level is decided one cycle ahead of each bit.
  always_comb begin
    w_tx_state_next   = r_tx_state;
    w_tx_next         = r_tx;
    w_tx_busy_next    = r_tx_busy;
    w_tx_shift_next   = r_tx_shift;
    w_tx_bit_next     = r_tx_bit;
    w_tx_clr          = 1'b0;
`ifdef UART_PARITY_EN
    w_tx_par_on_next  = r_tx_par_on;
    w_tx_par_bit_next = r_tx_par_bit;
`endif
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_clr       = 1'b1;
        w_tx_next      = 1'b1;
        w_tx_busy_next = 1'b0;
        if (wr_en) begin
          w_tx_state_next   = ST_START;
          w_tx_next         = 1'b0;
          w_tx_busy_next    = 1'b1;
          w_tx_shift_next   = din;
          w_tx_bit_next     = '0;
`ifdef UART_PARITY_EN
          w_tx_par_on_next  = par_enabled(parity_mode);
          w_tx_par_bit_next = (^din) ^ (parity_mode == PAR_ODD);
`endif
        end
      end
      ST_START: begin
        if (w_tx_eob) begin
          w_tx_state_next = ST_DATA;
          w_tx_next       = r_tx_shift[0];
          w_tx_shift_next = r_tx_shift >> 1;
        end
      end
      ST_DATA: begin
        if (w_tx_eob) begin
          if (r_tx_bit == LAST_DATA) begin
            w_tx_bit_next = '0;
`ifdef UART_PARITY_EN
            if (r_tx_par_on) begin
              w_tx_state_next = ST_PARITY;
              w_tx_next       = r_tx_par_bit;
            end else begin
              w_tx_state_next = ST_STOP;
              w_tx_next       = 1'b1;
            end
`else
            w_tx_state_next = ST_STOP;
            w_tx_next       = 1'b1;
`endif
          end else begin
            w_tx_bit_next   = r_tx_bit + 1'b1;
            w_tx_next       = r_tx_shift[0];
            w_tx_shift_next = r_tx_shift >> 1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (w_tx_eob) begin
          w_tx_state_next = ST_STOP;
          w_tx_next       = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_tx_eob) begin
          if (r_tx_bit == LAST_STOP) begin
            w_tx_state_next = ST_IDLE;
            w_tx_next       = 1'b1;
            w_tx_busy_next  = 1'b0;
          end else begin
            w_tx_bit_next = r_tx_bit + 1'b1;
          end
        end
      end
      default: begin
        w_tx_state_next = ST_IDLE;
        w_tx_next       = 1'b1;
        w_tx_busy_next  = 1'b0;
      end
    endcase
  end

  assign tx      = r_tx;
  assign tx_busy = r_tx_busy;

  // ---------------- receiver ----------------
  logic              r_rx_s1, r_rx_s2, r_rx_prev;
  uart_state_e       r_rx_state, w_rx_state_next;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_next;
  logic [BIT_W-1:0]  r_rx_bit, w_rx_bit_next;
  logic [DATA_W-1:0] r_dout, w_dout_next;
  logic              r_ready, w_ready_next;
  logic              r_ferr, w_ferr_next;
  logic              w_rx_clr, w_rx_mid, w_rx_eob;
`ifdef UART_PARITY_EN
  logic              r_rx_par_on, w_rx_par_on_next;
  logic              r_rx_par_odd, w_rx_par_odd_next;
  logic              r_rx_par_bit, w_rx_par_bit_next;
  logic              r_perr, w_perr_next;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_rx_clr),
    .o_mid (w_rx_mid),
    .o_eob (w_rx_eob)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= ST_IDLE;
      r_rx_shift   <= '0;
      r_rx_bit     <= '0;
      r_dout       <= '0;
      r_ready      <= 1'b0;
      r_ferr       <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_on  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_par_bit <= 1'b0;
      r_perr       <= 1'b0;
`endif
    end else begin
      r_rx_s1      <= rx;
      r_rx_s2      <= r_rx_s1;
      r_rx_prev    <= r_rx_s2;
      r_rx_state   <= w_rx_state_next;
      r_rx_shift   <= w_rx_shift_next;
      r_rx_bit     <= w_rx_bit_next;
      r_dout       <= w_dout_next;
      r_ready      <= w_ready_next;
      r_ferr       <= w_ferr_next;
`ifdef UART_PARITY_EN
      r_rx_par_on  <= w_rx_par_on_next;
      r_rx_par_odd <= w_rx_par_odd_next;
      r_rx_par_bit <= w_rx_par_bit_next;
      r_perr       <= w_perr_next;
`endif
    end
  end

  // A low stop bit leaves the line low; re-arming needs a fresh 1->0 edge, so it waits for idle.
  always_comb begin
    w_rx_state_next   = r_rx_state;
    w_rx_shift_next   = r_rx_shift;
    w_rx_bit_next     = r_rx_bit;
    w_dout_next       = r_dout;
    w_ready_next      = 1'b0;
    w_ferr_next       = r_ferr;
    w_rx_clr          = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_par_on_next  = r_rx_par_on;
    w_rx_par_odd_next = r_rx_par_odd;
    w_rx_par_bit_next = r_rx_par_bit;
    w_perr_next       = r_perr;
`endif
    case (r_rx_state)
      ST_IDLE: begin
        w_rx_clr = 1'b1;
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_rx_mid) begin
          if (r_rx_s2) begin
            w_rx_state_next = ST_IDLE;
          end else begin
`ifdef UART_PARITY_EN
            w_rx_par_on_next  = par_enabled(parity_mode);
            w_rx_par_odd_next = (parity_mode == PAR_ODD);
`endif
          end
        end else if (w_rx_eob) begin
          w_rx_state_next = ST_DATA;
          w_rx_bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (w_rx_mid) begin
          w_rx_shift_next = {r_rx_s2, r_rx_shift[DATA_W-1:1]};
        end else if (w_rx_eob) begin
          if (r_rx_bit == LAST_DATA) begin
`ifdef UART_PARITY_EN
            w_rx_state_next = r_rx_par_on ? ST_PARITY : ST_STOP;
`else
            w_rx_state_next = ST_STOP;
`endif
          end else begin
            w_rx_bit_next = r_rx_bit + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (w_rx_mid) begin
          w_rx_par_bit_next = r_rx_s2;
        end else if (w_rx_eob) begin
          w_rx_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_rx_mid) begin
          w_dout_next     = r_rx_shift;
          w_ready_next    = 1'b1;
          w_ferr_next     = ~r_rx_s2;
          w_rx_state_next = ST_IDLE;
`ifdef UART_PARITY_EN
          w_perr_next = r_rx_par_on &&
                        (((^r_rx_shift) ^ r_rx_par_odd) != r_rx_par_bit);
`endif
        end
      end
      default: begin
        w_rx_state_next = ST_IDLE;
      end
    endcase
  end

  assign dout      = r_dout;
  assign ready     = r_ready;
  assign frame_err = r_ferr;

`ifdef UART_PARITY_EN
  assign parity_err = r_perr;
`else
  logic w_unused_par;
  assign w_unused_par = par_enabled(parity_mode);
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed bench for uart_xcvr_param: loopback frames, external RX frames, glitch and reset cases.
// Expectations follow UART_PARITY_EN when the build defines it.
module tb_uart_xcvr_param;

`ifdef UART_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic       tx, tx_busy;
  logic       rx_line;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;
  logic [7:0] dout;
  logic       ready, parity_err, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_cnt  = 0;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_xcvr_param #(.DATA_W(8), .CLKS_PER_BIT(16), .STOP_BITS(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .wr_en       (wr_en),
    .parity_mode (parity_mode),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .rx          (rx_line),
    .dout        (dout),
    .ready       (ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );

  // Counts cycles with ready high; sampled at posedge so it sees the settled previous-cycle value.
  always @(posedge clk) begin
    if (ready === 1'b1) rdy_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit par_on(input logic [1:0] m);
    return PAR_BUILD && ((m == 2'b01) || (m == 2'b10));
  endfunction

  // Line levels of one frame, bit 0 = start bit.
  function automatic logic [15:0] exp_frame(input logic [7:0] d, input logic [1:0] m);
    logic [15:0] f;
    f = '0;
    f[8:1] = d;
    if (par_on(m)) begin
      f[9]  = (^d) ^ (m == 2'b10);
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [1:0] m, input int inject_at);
    int c;
    int r0;
    int nb;
    logic [15:0] cap;
    c = 0;
    while (tx_busy === 1'b1 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    nb  = par_on(m) ? 11 : 10;
    r0  = rdy_cnt;
    cap = '0;
    din = d;
    parity_mode = m;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check_val("tx_busy_rise", {31'd0, tx_busy}, 32'd1);
    check_val("tx_start_bit", {31'd0, tx}, 32'd0);
    c = 0;
    while (tx_busy === 1'b1 && c < 400) begin
      if ((c % 16) == 8 && c < 256) cap[c/16] = tx;
      if (c == inject_at) begin
        din   = 8'h55;
        wr_en = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    wr_en = 1'b0;
    check_val("frame_len", c, nb * 16);
    check_val("tx_bits", {16'd0, cap}, {16'd0, exp_frame(d, m)});
    for (int k = 0; k < 40 && rdy_cnt == r0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_val("ready_pulses", rdy_cnt - r0, 1);
    check_val("dout", {24'd0, dout}, {24'd0, d});
    check_val("parity_err", {31'd0, parity_err}, 32'd0);
    check_val("frame_err", {31'd0, frame_err}, 32'd0);
    $display("tx frame din=%02h mode=%b busy_cycles=%0d dout=%02h perr=%b ferr=%b",
             d, m, c, dout, parity_err, frame_err);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic [1:0] m, input logic par_bit,
                          input logic stop_bit, input logic idle_lvl);
    logic [15:0] f;
    int nb;
    f = '0;
    parity_mode = m;
    f[8:1] = d;
    nb = 9;
    if (par_on(m)) begin
      f[9] = par_bit;
      nb = 10;
    end
    f[nb] = stop_bit;
    nb++;
    for (int b = 0; b < nb; b++) begin
      rx_drv = f[b];
      repeat (16) @(negedge clk);
    end
    rx_drv = idle_lvl;
    repeat (4) @(negedge clk);
    $display("rx frame data=%02h mode=%b par=%b stop=%b dout=%02h perr=%b ferr=%b",
             d, m, par_bit, stop_bit, dout, parity_err, frame_err);
  endtask

  logic [7:0] words [8] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C, 8'hC3};
  logic [1:0] modes [3] = '{2'b00, 2'b01, 2'b10};

  initial begin
    int r0;
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx", {31'd0, tx}, 32'd1);
    check_val("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check_val("rst_dout", {24'd0, dout}, 32'd0);
    check_val("rst_ready", {31'd0, ready}, 32'd0);
    check_val("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Loopback, mode 01, 8'hCE
    send_frame(8'hCE, 2'b01, -1);

    // Loopback sweep over a word table and the three modes, plus mode 11
    foreach (modes[mi]) begin
      foreach (words[wi]) begin
        send_frame(words[wi], modes[mi], -1);
      end
    end
    send_frame(8'hA5, 2'b11, -1);

    // wr_en mid-frame must be ignored
    send_frame(8'h0F, 2'b01, 70);

    // External RX: odd parity, data 01, wrong parity bit (correct would be 0)
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (20) @(negedge clk);
    r0 = rdy_cnt;
    drive_rx(8'h01, 2'b10, 1'b1, 1'b1, 1'b1);
    check_val("ext_par_ready", rdy_cnt - r0, 1);
    check_val("ext_par_dout", {24'd0, dout}, 32'h01);
    check_val("ext_par_err", {31'd0, parity_err}, {31'd0, PAR_BUILD});
    check_val("ext_par_ferr", {31'd0, frame_err}, 32'd0);

    // External RX: even parity, data 07, correct parity bit 1
    r0 = rdy_cnt;
    drive_rx(8'h07, 2'b01, 1'b1, 1'b1, 1'b1);
    check_val("ext_ok_ready", rdy_cnt - r0, 1);
    check_val("ext_ok_dout", {24'd0, dout}, 32'h07);
    check_val("ext_ok_perr", {31'd0, parity_err}, 32'd0);

    // Stop bit low, line held low afterwards
    repeat (10) @(negedge clk);
    r0 = rdy_cnt;
    drive_rx(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0);
    check_val("ferr_ready", rdy_cnt - r0, 1);
    check_val("ferr_dout", {24'd0, dout}, 32'h3C);
    check_val("ferr_flag", {31'd0, frame_err}, 32'd1);
    r0 = rdy_cnt;
    repeat (80) @(negedge clk);
    check_val("ferr_no_rearm", rdy_cnt - r0, 0);
    check_val("ferr_hold", {31'd0, frame_err}, 32'd1);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    r0 = rdy_cnt;
    drive_rx(8'h5A, 2'b00, 1'b0, 1'b1, 1'b1);
    check_val("recover_ready", rdy_cnt - r0, 1);
    check_val("recover_dout", {24'd0, dout}, 32'h5A);
    check_val("recover_ferr", {31'd0, frame_err}, 32'd0);

    // Three-cycle low glitch must not produce a frame
    r0 = rdy_cnt;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check_val("glitch_no_ready", rdy_cnt - r0, 0);
    check_val("glitch_dout_hold", {24'd0, dout}, 32'h5A);
    $display("rx glitch 3 cycles ready_pulses=%0d", rdy_cnt - r0);

    // Reset in the middle of DATA on both directions
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    din = 8'hC3;
    parity_mode = 2'b00;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (16 * 3 + 5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("mid_rst_tx", {31'd0, tx}, 32'd1);
    check_val("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    check_val("mid_rst_dout", {24'd0, dout}, 32'd0);
    check_val("mid_rst_ready", {31'd0, ready}, 32'd0);
    check_val("mid_rst_perr", {31'd0, parity_err}, 32'd0);
    check_val("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    $display("reset mid-frame tx=%b busy=%b dout=%02h", tx, tx_busy, dout);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    r0 = rdy_cnt;
    repeat (200) @(negedge clk);
    check_val("post_rst_no_ready", rdy_cnt - r0, 0);
    send_frame(8'hA5, 2'b00, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
